// File: rtl/sum_fact_pkg.sv
// Shared definitions for the sum/factorial engine.
//   - state_t   : controller states (IDLE, CALC, DONE)
//   - MODE_SUM  : mode value selecting 1!+...+N!
//   - MODE_FACT : mode value selecting N!
//   - N_W_DEF   : default operand width
//   - OUT_W_DEF : default result width (holds 1!+...+7! = 5913)
package sum_fact_pkg;

    localparam int N_W_DEF   = 3;
    localparam int OUT_W_DEF = 13;

    localparam logic MODE_SUM  = 1'b0;
    localparam logic MODE_FACT = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/sum_fact_step.sv
// One iteration of the factorial / running-sum recurrence (pure combinational).
// Ports:
//   i_fact  [OUT_W-1:0] : current factorial value (k-1)!, truncated
//   i_sum   [OUT_W-1:0] : current running sum, truncated
//   i_k     [N_W-1:0]   : multiplier for this step
//   i_mode              : MODE_SUM / MODE_FACT, selects which overflow path counts
//   o_fact  [OUT_W-1:0] : i_fact * i_k, truncated
//   o_sum   [OUT_W-1:0] : i_sum + i_fact * i_k, truncated
//   o_ovf               : this step lost information on the selected path
module sum_fact_step
    import sum_fact_pkg::*;
#(
    parameter int N_W   = N_W_DEF,
    parameter int OUT_W = OUT_W_DEF
) (
    input  logic [OUT_W-1:0] i_fact,
    input  logic [OUT_W-1:0] i_sum,
    input  logic [N_W-1:0]   i_k,
    input  logic             i_mode,
    output logic [OUT_W-1:0] o_fact,
    output logic [OUT_W-1:0] o_sum,
    output logic             o_ovf
);

    localparam int WIDE_W = OUT_W + N_W;

    logic [WIDE_W-1:0] w_prod;
    logic [WIDE_W-1:0] w_sum;
    logic              w_prod_ovf;
    logic              w_sum_ovf;

    always_comb begin
        // An OUT_W x N_W product always fits in WIDE_W bits.
        w_prod     = {{N_W{1'b0}}, i_fact} * {{OUT_W{1'b0}}, i_k};
        w_sum      = {{N_W{1'b0}}, i_sum} + w_prod;
        w_prod_ovf = |w_prod[WIDE_W-1:OUT_W];
        // The sum path also inherits any product loss, since the lost
        // product bits belong to the true sum as well.
        w_sum_ovf  = w_prod_ovf | (|w_sum[WIDE_W-1:OUT_W]);
        o_fact     = w_prod[OUT_W-1:0];
        o_sum      = w_sum[OUT_W-1:0];
        o_ovf      = (i_mode == MODE_SUM) ? w_sum_ovf : w_prod_ovf;
    end

endmodule

// File: rtl/sum_fact_param.sv
// Iterative engine computing N! or 1!+...+N!, one multiply per clock.
// Ports:
//   clk                      : clock, rising edge
//   reset                    : asynchronous active-high reset
//   N_in         [N_W-1:0]   : operand N, sampled on accept
//   mode                     : MODE_SUM / MODE_FACT, sampled on accept
//   input_valid              : request strobe
//   input_ready              : high in IDLE only
//   sum_fact     [OUT_W-1:0] : result modulo 2^OUT_W (0 when not valid)
//   overflow                 : true result exceeded OUT_W bits
//   output_valid             : high in DONE only
//   output_ack               : consumer took the result
module sum_fact_param
    import sum_fact_pkg::*;
#(
    parameter int N_W   = N_W_DEF,
    parameter int OUT_W = OUT_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_W-1:0]   N_in,
    input  logic             mode,
    input  logic             input_valid,
    output logic             input_ready,
    output logic [OUT_W-1:0] sum_fact,
    output logic             overflow,
    output logic             output_valid,
    input  logic             output_ack
);

    state_t r_state;
    state_t w_state_nxt;

    logic [N_W-1:0]   r_n;
    logic [N_W-1:0]   r_k;
    logic             r_mode;
    logic [OUT_W-1:0] r_fact;
    logic [OUT_W-1:0] r_sum;
    logic             r_ovf;

    logic             w_accept;
    logic [OUT_W-1:0] w_fact_nxt;
    logic [OUT_W-1:0] w_sum_nxt;
    logic             w_step_ovf;

    sum_fact_step #(
        .N_W   (N_W),
        .OUT_W (OUT_W)
    ) u_step (
        .i_fact (r_fact),
        .i_sum  (r_sum),
        .i_k    (r_k),
        .i_mode (r_mode),
        .o_fact (w_fact_nxt),
        .o_sum  (w_sum_nxt),
        .o_ovf  (w_step_ovf)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        input_ready  = 1'b0;
        output_valid = 1'b0;
        case (r_state)
            ST_IDLE: begin
                input_ready = 1'b1;
                if (input_valid) begin
                    w_state_nxt = (N_in == '0) ? ST_DONE : ST_CALC;
                end
            end
            ST_CALC: begin
                // r_k is the multiplier being applied on this edge.
                if (r_k == r_n) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                output_valid = 1'b1;
                if (output_ack) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign w_accept = input_valid & input_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_n    <= '0;
            r_k    <= '0;
            r_mode <= 1'b0;
            r_fact <= OUT_W'(1);
            r_sum  <= '0;
            r_ovf  <= 1'b0;
        end else if (w_accept) begin
            r_n    <= N_in;
            r_mode <= mode;
            r_fact <= OUT_W'(1);
            r_sum  <= '0;
            r_k    <= N_W'(1);
            r_ovf  <= 1'b0;
        end else if (r_state == ST_CALC) begin
            r_fact <= w_fact_nxt;
            r_sum  <= w_sum_nxt;
            r_k    <= r_k + N_W'(1);
            r_ovf  <= r_ovf | w_step_ovf;
        end
    end

    // Outputs are gated by DONE so reset and idle both read zero at once.
    always_comb begin
        sum_fact = '0;
        overflow = 1'b0;
        if (output_valid) begin
            sum_fact = (r_mode == MODE_FACT) ? r_fact : r_sum;
            overflow = r_ovf;
        end
    end

endmodule

// File: tb/tb_sum_fact_param.sv
module tb_sum_fact_param;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  n_in;
    logic        mode_in;
    logic        tb_valid;
    logic        tb_ack;
    int          sel;

    logic [2:0]  v_vec, a_vec;
    logic [2:0]  ir, ov, of;
    logic [12:0] sf_a;
    logic [7:0]  sf_b;
    logic [47:0] sf_c;

    logic        o_ready, o_valid, o_ovf;
    logic [63:0] o_sf;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    always_comb begin
        v_vec = '0;
        a_vec = '0;
        v_vec[sel] = tb_valid;
        a_vec[sel] = tb_ack;
        o_ready = ir[sel];
        o_valid = ov[sel];
        o_ovf   = of[sel];
        case (sel)
            0:       o_sf = 64'(sf_a);
            1:       o_sf = 64'(sf_b);
            default: o_sf = 64'(sf_c);
        endcase
    end

    sum_fact_param u_a (
        .clk(clk), .reset(reset), .N_in(n_in[2:0]), .mode(mode_in),
        .input_valid(v_vec[0]), .input_ready(ir[0]), .sum_fact(sf_a),
        .overflow(of[0]), .output_valid(ov[0]), .output_ack(a_vec[0])
    );

    sum_fact_param #(.N_W(3), .OUT_W(8)) u_b (
        .clk(clk), .reset(reset), .N_in(n_in[2:0]), .mode(mode_in),
        .input_valid(v_vec[1]), .input_ready(ir[1]), .sum_fact(sf_b),
        .overflow(of[1]), .output_valid(ov[1]), .output_ack(a_vec[1])
    );

    sum_fact_param #(.N_W(4), .OUT_W(48)) u_c (
        .clk(clk), .reset(reset), .N_in(n_in), .mode(mode_in),
        .input_valid(v_vec[2]), .input_ready(ir[2]), .sum_fact(sf_c),
        .overflow(of[2]), .output_valid(ov[2]), .output_ack(a_vec[2])
    );

    function automatic int w_of(input int s);
        case (s)
            0:       return 13;
            1:       return 8;
            default: return 48;
        endcase
    endfunction

    function automatic int nmax_of(input int s);
        return (s == 2) ? 15 : 7;
    endfunction

    // Reference: exact factorial / sum in 64 bits, then reduce to w bits.
    // Overflow is simply "true value does not fit"; both quantities grow
    // monotonically so any intermediate loss implies the final one.
    function automatic void model(input int n, input bit m, input int w,
                                  output logic [63:0] r, output bit o);
        logic [63:0] f, s, v;
        f = 64'd1;
        s = 64'd0;
        for (int k = 1; k <= n; k++) begin
            f = f * 64'(k);
            s = s + f;
        end
        v = m ? f : s;
        o = (v >= (64'd1 << w));
        r = v & ((64'd1 << w) - 64'd1);
    endfunction

    task automatic run_req(input int n, input bit m, input bit disturb,
                           input int hold, input bit ack_with_valid);
        logic [63:0] exp_v;
        bit          exp_o;
        int          lat;
        model(n, m, w_of(sel), exp_v, exp_o);
        @(negedge clk);
        n_vec++;
        if (o_ready !== 1'b1) begin
            n_err++;
            $display("FAIL ready_before_req: got %b want 1", o_ready);
        end
        n_in     = 4'(n);
        mode_in  = m;
        tb_valid = 1'b1;
        @(posedge clk);
        #1;
        tb_valid = 1'b0;
        n_in     = 4'($urandom);
        mode_in  = 1'($urandom);
        lat = 0;
        @(negedge clk);
        while (o_valid !== 1'b1 && lat < 40) begin
            n_vec++;
            if (o_ready !== 1'b0) begin
                n_err++;
                $display("FAIL ready_in_calc: got %b want 0", o_ready);
            end
            if (disturb) begin
                tb_valid = 1'b1;
                n_in     = 4'($urandom);
                mode_in  = ~m;
                tb_ack   = 1'($urandom);
            end
            @(posedge clk);
            #1;
            tb_valid = 1'b0;
            tb_ack   = 1'b0;
            lat++;
            @(negedge clk);
        end
        n_vec++;
        if (lat != n) begin
            n_err++;
            $display("FAIL latency n=%0d: got %0d want %0d", n, lat, n);
        end
        n_vec++;
        if (o_sf !== exp_v || o_ovf !== exp_o) begin
            n_err++;
            $display("FAIL result sel=%0d n=%0d m=%0d: got %0d/%b want %0d/%b",
                     sel, n, m, o_sf, o_ovf, exp_v, exp_o);
        end
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            @(negedge clk);
            n_vec++;
            if (o_valid !== 1'b1 || o_sf !== exp_v || o_ovf !== exp_o) begin
                n_err++;
                $display("FAIL hold cyc=%0d: got v=%b %0d/%b want v=1 %0d/%b",
                         i, o_valid, o_sf, o_ovf, exp_v, exp_o);
            end
        end
        tb_ack = 1'b1;
        if (ack_with_valid) tb_valid = 1'b1;
        @(posedge clk);
        #1;
        tb_ack   = 1'b0;
        tb_valid = 1'b0;
        @(negedge clk);
        n_vec++;
        if (o_valid !== 1'b0 || o_ready !== 1'b1 || o_sf !== 64'd0) begin
            n_err++;
            $display("FAIL after_ack: got v=%b r=%b sf=%0d want v=0 r=1 sf=0",
                     o_valid, o_ready, o_sf);
        end
    endtask

    task automatic test_reset();
        for (int s = 0; s < 3; s++) begin
            sel = s;
            #1;
            n_vec++;
            if (o_valid !== 1'b0 || o_sf !== 64'd0 || o_ovf !== 1'b0 || o_ready !== 1'b1) begin
                n_err++;
                $display("FAIL reset_state sel=%0d: got v=%b sf=%0d o=%b r=%b want 0 0 0 1",
                         s, o_valid, o_sf, o_ovf, o_ready);
            end
        end
        sel = 0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_known();
        sel = 0;
        run_req(7, 1'b0, 1'b0, 3, 1'b0);
        run_req(7, 1'b1, 1'b0, 1, 1'b0);
        run_req(0, 1'b0, 1'b0, 1, 1'b0);
        run_req(0, 1'b1, 1'b0, 1, 1'b0);
    endtask

    task automatic test_idle_ack();
        sel = 0;
        @(negedge clk);
        tb_ack = 1'b1;
        @(posedge clk);
        #1;
        tb_ack = 1'b0;
        @(negedge clk);
        n_vec++;
        if (o_ready !== 1'b1 || o_valid !== 1'b0) begin
            n_err++;
            $display("FAIL idle_ack: got r=%b v=%b want r=1 v=0", o_ready, o_valid);
        end
    endtask

    task automatic test_disturb();
        sel = 0;
        run_req(5, 1'b0, 1'b1, 2, 1'b0);
        run_req(6, 1'b1, 1'b1, 0, 1'b0);
        sel = 1;
        run_req(7, 1'b0, 1'b1, 1, 1'b0);
    endtask

    task automatic test_back_to_back();
        sel = 0;
        run_req(4, 1'b1, 1'b0, 0, 1'b1);
        run_req(3, 1'b0, 1'b0, 0, 1'b1);
        run_req(2, 1'b0, 1'b0, 0, 1'b0);
    endtask

    task automatic test_ack_hold();
        int cnt;
        logic [63:0] exp_v;
        bit          exp_o;
        sel = 0;
        model(3, 1'b0, 13, exp_v, exp_o);
        cnt = 0;
        @(negedge clk);
        tb_ack   = 1'b1;
        n_in     = 4'd3;
        mode_in  = 1'b0;
        tb_valid = 1'b1;
        @(posedge clk);
        #1;
        tb_valid = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (o_valid === 1'b1) begin
                cnt++;
                n_vec++;
                if (o_sf !== exp_v || o_ovf !== exp_o) begin
                    n_err++;
                    $display("FAIL ack_hold_value: got %0d/%b want %0d/%b",
                             o_sf, o_ovf, exp_v, exp_o);
                end
            end
            @(posedge clk);
        end
        tb_ack = 1'b0;
        @(negedge clk);
        n_vec++;
        if (cnt != 1 || o_ready !== 1'b1) begin
            n_err++;
            $display("FAIL ack_hold_count: got %0d results r=%b want 1 r=1", cnt, o_ready);
        end
    endtask

    task automatic test_reset_mid();
        sel = 0;
        @(negedge clk);
        n_in = 4'd7; mode_in = 1'b1; tb_valid = 1'b1;
        @(posedge clk);
        #1;
        tb_valid = 1'b0;
        repeat (3) @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        n_vec++;
        if (o_valid !== 1'b0 || o_sf !== 64'd0 || o_ovf !== 1'b0 || o_ready !== 1'b1) begin
            n_err++;
            $display("FAIL reset_mid_calc: got v=%b sf=%0d o=%b r=%b want 0 0 0 1",
                     o_valid, o_sf, o_ovf, o_ready);
        end
        @(negedge clk);
        reset = 1'b0;
        // Reset while a result is being presented.
        @(negedge clk);
        n_in = 4'd0; mode_in = 1'b1; tb_valid = 1'b1;
        @(posedge clk);
        #1;
        tb_valid = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        n_vec++;
        if (o_valid !== 1'b0 || o_sf !== 64'd0 || o_ready !== 1'b1) begin
            n_err++;
            $display("FAIL reset_in_done: got v=%b sf=%0d r=%b want 0 0 1",
                     o_valid, o_sf, o_ready);
        end
        @(negedge clk);
        reset = 1'b0;
        run_req(3, 1'b0, 1'b0, 0, 1'b0);
    endtask

    task automatic test_param_widths();
        sel = 1;
        run_req(7, 1'b0, 1'b0, 0, 1'b0);
        run_req(7, 1'b1, 1'b0, 0, 1'b0);
        run_req(5, 1'b1, 1'b0, 0, 1'b0);
        sel = 2;
        run_req(15, 1'b1, 1'b0, 1, 1'b0);
        run_req(15, 1'b0, 1'b0, 0, 1'b0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 25; i++) begin
            sel = int'($urandom_range(2, 0));
            run_req(int'($urandom_range(nmax_of(sel), 0)), 1'($urandom),
                    1'($urandom), int'($urandom_range(3, 0)), 1'($urandom));
        end
    endtask

    initial begin
        reset    = 1'b1;
        tb_valid = 1'b0;
        tb_ack   = 1'b0;
        n_in     = '0;
        mode_in  = 1'b0;
        sel      = 0;
        #12;
        test_reset();
        test_known();
        test_idle_ack();
        test_disturb();
        test_back_to_back();
        test_ack_hold();
        test_reset_mid();
        test_param_widths();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
